// File: rtl/eth_st_ready_latency_adapter.sv
// Show-ahead elastic buffer adapting an upstream ready-latency source to a ready-latency-0 sink.
// Write-to-output latency 1 cycle; full-buffer writes are dropped and flagged; ST_TA_DROP_CNT_EN adds drop_cnt.
module eth_st_ready_latency_adapter #(
  parameter int DATA_W           = 72,
  parameter int DEPTH            = 8,
  parameter int IN_READY_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic                      overflow,
  input  logic                      clr_overflow
`ifdef ST_TA_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              overflow_q, overflow_d;
  logic              rd, wr, drop;

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign in_ready   = in_ready_q;
  assign fill_level = count_q;
  assign overflow   = overflow_q;

  always_comb begin
    rd   = out_valid & out_ready;
    // A read in the same cycle frees the slot, so a full buffer can still accept.
    wr   = in_valid & ((count_q < CNT_W'(DEPTH)) | rd);
    drop = in_valid & ~wr;

    wr_ptr_d   = wr_ptr_q + AW'(wr);
    rd_ptr_d   = rd_ptr_q + AW'(rd);
    count_d    = count_q + CNT_W'(wr) - CNT_W'(rd);
    // Leave room for the beats still in flight from the upstream ready latency.
    in_ready_d = (count_d <= CNT_W'(DEPTH - 1 - IN_READY_LATENCY));

    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately not reset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef ST_TA_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow)
      drop_cnt_d = drop ? 16'd1 : 16'd0;
    else if (drop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_eth_st_ready_latency_adapter.sv
// Directed bench for eth_st_ready_latency_adapter with a queue-based reference model.
module tb_eth_st_ready_latency_adapter;
  parameter int IRL = 1;
  localparam int DATA_W = 72;
  localparam int DEPTH  = 8;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW:0]       fill_level;
  logic              overflow;
  logic              clr_overflow = 1'b0;
`ifdef ST_TA_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  eth_st_ready_latency_adapter #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .IN_READY_LATENCY(IRL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .overflow(overflow), .clr_overflow(clr_overflow)
`ifdef ST_TA_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a plain FIFO of beats plus flag/counter bookkeeping.
  logic [DATA_W-1:0] mq[$];
  bit m_ovf, m_rdy, m_rd, m_wr, m_drop;
  int m_dc;

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_ovf = 0; m_dc = 0; m_rdy = 0;
    end else begin
      m_rd   = (mq.size() != 0) && out_ready;
      m_wr   = in_valid && ((mq.size() < DEPTH) || m_rd);
      m_drop = in_valid && !m_wr;
      if (m_rd) void'(mq.pop_front());
      if (m_wr) mq.push_back(in_data);
      m_rdy = (mq.size() <= DEPTH - 1 - IRL);
      if (m_drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      if (clr_overflow) m_dc = m_drop ? 1 : 0;
      else if (m_drop && m_dc < 65535) m_dc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() != 0));
      chk("fill_level", DATA_W'(fill_level), DATA_W'(mq.size()));
      chk("in_ready", DATA_W'(in_ready), DATA_W'(m_rdy));
      chk("overflow", DATA_W'(overflow), DATA_W'(m_ovf));
      if (mq.size() != 0) chk("out_data", out_data, mq[0]);
`ifdef ST_TA_DROP_CNT_EN
      chk("drop_cnt", DATA_W'(drop_cnt), DATA_W'(m_dc));
`endif
    end
  end

  bit rdy_hist[5];
  int seq = 0;

  function automatic logic [DATA_W-1:0] beat(input int s);
    return {8'h5A, 32'(s), ~32'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 4; i > 0; i--) rdy_hist[i] = rdy_hist[i-1];
    rdy_hist[0] = in_ready;
  endtask

  // Present a beat only when in_ready was high IRL cycles ago.
  task automatic honoured_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = rdy_hist[IRL];
      if (in_valid) begin in_data = beat(seq); seq++; end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic forced_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = beat(seq); seq++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && fill_level != '0; i++) tick();
    chk("drain_empty", DATA_W'(fill_level), DATA_W'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_fill", DATA_W'(fill_level), DATA_W'(0));
    chk("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
    chk("rst_overflow", DATA_W'(overflow), DATA_W'(0));
    reset_n = 1'b1;
    tick();
    chk("rel_in_ready", DATA_W'(in_ready), DATA_W'(1));

    // 1: streaming with downstream always ready
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = beat(seq); seq++;
    tick();
    chk("t1_first_valid", DATA_W'(out_valid), DATA_W'(1));
    chk("t1_first_data", out_data, beat(0));
    honoured_cycles(19);
    tick();
    chk("t1_fill_end", DATA_W'(fill_level), DATA_W'(0));
    chk("t1_seq", DATA_W'(seq), DATA_W'(20));
    out_ready = 1'b0;

    // 2: backpressure with a compliant source
    honoured_cycles(20);
    chk("t2_fill_peak", DATA_W'(fill_level), DATA_W'(DEPTH));
    chk("t2_in_ready", DATA_W'(in_ready), DATA_W'(0));
    chk("t2_no_ovf", DATA_W'(overflow), DATA_W'(0));
    drain();

    // 3: forced writes into a full buffer
    forced_cycles(DEPTH);
    chk("t3_head", out_data, beat(seq - DEPTH));
    forced_cycles(3);
    chk("t3_fill", DATA_W'(fill_level), DATA_W'(DEPTH));
    chk("t3_ovf", DATA_W'(overflow), DATA_W'(1));
    chk("t3_head_kept", out_data, beat(seq - DEPTH - 3));
`ifdef ST_TA_DROP_CNT_EN
    chk("t3_drop_cnt", DATA_W'(drop_cnt), DATA_W'(3));
`endif

    // 4: simultaneous read and write while full
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    out_ready = 1'b1;
    forced_cycles(1);
    out_ready = 1'b0;
    chk("t4_fill", DATA_W'(fill_level), DATA_W'(DEPTH));
    chk("t4_ovf", DATA_W'(overflow), DATA_W'(0));
    out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
    chk("t4_fill5", DATA_W'(fill_level), DATA_W'(5));

    // 5: reset mid-stream
    reset_n = 1'b0; tick();
    chk("t5_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("t5_fill", DATA_W'(fill_level), DATA_W'(0));
    chk("t5_in_ready", DATA_W'(in_ready), DATA_W'(0));
    reset_n = 1'b1; tick();
    chk("t5_in_ready_rel", DATA_W'(in_ready), DATA_W'(1));

    // 6: clear coinciding with a new drop
    forced_cycles(DEPTH + 2);
    chk("t6_ovf_pre", DATA_W'(overflow), DATA_W'(1));
`ifdef ST_TA_DROP_CNT_EN
    chk("t6_dc_pre", DATA_W'(drop_cnt), DATA_W'(2));
`endif
    clr_overflow = 1'b1;
    forced_cycles(1);
    clr_overflow = 1'b0;
    chk("t6_ovf_set_wins", DATA_W'(overflow), DATA_W'(1));
`ifdef ST_TA_DROP_CNT_EN
    chk("t6_dc_one", DATA_W'(drop_cnt), DATA_W'(1));
`endif
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t6_ovf_clr", DATA_W'(overflow), DATA_W'(0));
    drain();

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
